// File: rtl/bn128_pkg.sv
// Shared bn128 types: field element, affine point and the base-field modulus.
package bn128_pkg;

    localparam int DAT_BITS = 256;
    localparam int CNT_BITS = 64;

    typedef logic [255:0] fe_t;

    // Affine point; x occupies the low half so the packed image is {y, x}.
    typedef struct packed {
        fe_t y;
        fe_t x;
    } affine_t;

    // bn128 base-field modulus.
    localparam fe_t P = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    // True when v is a canonical residue modulo m.
    function automatic logic fe_in_range(input fe_t v, input fe_t m);
        return (v < m);
    endfunction

endpackage

// File: rtl/bn128_loader_out_stage.sv
// Paired scalar/point holding register. Both valids rise together on load and
// clear independently on their own handshake. o_free tells the loader whether
// a new element could be loaded in this very cycle.
module bn128_loader_out_stage #(
    parameter int DAT_BITS = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DAT_BITS-1:0]   i_scl,
    input  logic [2*DAT_BITS-1:0] i_pnt,
    input  logic                  i_scl_rdy,
    input  logic                  i_pnt_rdy,
    output logic                  o_scl_val,
    output logic [DAT_BITS-1:0]   o_scl_dat,
    output logic                  o_pnt_val,
    output logic [2*DAT_BITS-1:0] o_pnt_dat,
    output logic                  o_free
);

    logic                  r_scl_val;
    logic [DAT_BITS-1:0]   r_scl_dat;
    logic                  r_pnt_val;
    logic [2*DAT_BITS-1:0] r_pnt_dat;

    // Free when every asserted valid is low or being taken this cycle.
    assign o_free = (~r_scl_val | i_scl_rdy) & (~r_pnt_val | i_pnt_rdy);

    // Holding registers: load both halves together, retire each on its own handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_val <= 1'b0;
            r_scl_dat <= '0;
            r_pnt_val <= 1'b0;
            r_pnt_dat <= '0;
        end else if (i_load) begin
            r_scl_val <= 1'b1;
            r_scl_dat <= i_scl;
            r_pnt_val <= 1'b1;
            r_pnt_dat <= i_pnt;
        end else begin
            if (r_scl_val && i_scl_rdy) begin
                r_scl_val <= 1'b0;
            end
            if (r_pnt_val && i_pnt_rdy) begin
                r_pnt_val <= 1'b0;
            end
        end
    end

    assign o_scl_val = r_scl_val;
    assign o_scl_dat = r_scl_dat;
    assign o_pnt_val = r_pnt_val;
    assign o_pnt_dat = r_pnt_dat;

endmodule

// File: rtl/bn128_multiexp_loader.sv
// Host-beat to scalar/point stream loader for the bn128 multiexp wrapper.
// Each element is three beats {scalar(sop), X, Y(eop)}; elements are counted
// against a programmed total and o_done pulses once all have been handed off.
// Optional feature: define BN128_LOADER_RANGE_CHECK_EN to drop elements whose
// X or Y coordinate is not below the modulus P.
module bn128_multiexp_loader
    import bn128_pkg::*;
#(
    parameter int  DAT_BITS = 256,
    parameter int  CNT_BITS = 64,
    parameter fe_t P        = bn128_pkg::P
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [CNT_BITS-1:0]   i_num_in,
    input  logic                  i_dat_val,
    input  logic                  i_dat_sop,
    input  logic                  i_dat_eop,
    input  logic [DAT_BITS-1:0]   i_dat,
    output logic                  o_dat_rdy,
    output logic                  o_scl_val,
    output logic [DAT_BITS-1:0]   o_scl_dat,
    input  logic                  i_scl_rdy,
    output logic                  o_pnt_val,
    output logic [2*DAT_BITS-1:0] o_pnt_dat,
    input  logic                  i_pnt_rdy,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCL  = 3'd1,
        S_PX   = 3'd2,
        S_PY   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_BITS-1:0]   r_cnt;
    logic [CNT_BITS-1:0]   r_num;
    logic [DAT_BITS-1:0]   r_scl;
    logic [DAT_BITS-1:0]   r_x;
    logic                  r_err;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_rdy;
    logic                  w_free;
    logic                  w_load;
    logic                  w_err_set;
    logic                  w_scl_store;
    logic                  w_x_store;
    logic                  w_cnt_inc;
    logic                  w_start_acc;
    logic                  w_range_bad;

`ifdef BN128_LOADER_RANGE_CHECK_EN
    // Combinational compare on the Y beat keeps the load latency unchanged.
    assign w_range_bad = ~fe_in_range(r_x, P) | ~fe_in_range(i_dat, P);
`else
    // No range check in this build; the term folds to zero and P drops out.
    assign w_range_bad = 1'b0 & (|P);
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, beat readiness and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_rdy       = 1'b0;
        w_load      = 1'b0;
        w_err_set   = 1'b0;
        w_scl_store = 1'b0;
        w_x_store   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = (i_num_in == {CNT_BITS{1'b0}}) ? S_DONE : S_SCL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SCL: begin
                if (r_cnt == r_num) begin
                    // All elements loaded; finish once the last pair drains.
                    w_state_nxt = w_free ? S_DONE : S_SCL;
                end else begin
                    w_rdy = 1'b1;
                    if (i_dat_val) begin
                        if (i_dat_sop) begin
                            w_scl_store = 1'b1;
                            w_err_set   = i_dat_eop;
                            w_state_nxt = S_PX;
                        end else begin
                            w_err_set   = 1'b1;
                            w_state_nxt = S_SCL;
                        end
                    end else begin
                        w_state_nxt = S_SCL;
                    end
                end
            end
            S_PX: begin
                w_rdy = 1'b1;
                if (i_dat_val) begin
                    if (!i_dat_sop && !i_dat_eop) begin
                        w_x_store   = 1'b1;
                        w_state_nxt = S_PY;
                    end else begin
                        // Bad framing: drop the partial element, a sop beat restarts one.
                        w_err_set   = 1'b1;
                        w_scl_store = i_dat_sop;
                        w_state_nxt = i_dat_sop ? S_PX : S_SCL;
                    end
                end else begin
                    w_state_nxt = S_PX;
                end
            end
            S_PY: begin
                w_rdy = w_free;
                if (i_dat_val && w_free) begin
                    if (!i_dat_sop && i_dat_eop) begin
                        if (w_range_bad) begin
                            w_err_set = 1'b1;
                        end else begin
                            w_load    = 1'b1;
                            w_cnt_inc = 1'b1;
                        end
                        w_state_nxt = S_SCL;
                    end else begin
                        w_err_set   = 1'b1;
                        w_scl_store = i_dat_sop;
                        w_state_nxt = i_dat_sop ? S_PX : S_SCL;
                    end
                end else begin
                    w_state_nxt = S_PY;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Run bookkeeping, element holding registers and status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_num  <= '0;
            r_scl  <= '0;
            r_x    <= '0;
            r_err  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
            if (w_start_acc) begin
                r_num <= i_num_in;
                r_cnt <= '0;
                r_err <= 1'b0;
            end else begin
                if (w_cnt_inc) begin
                    r_cnt <= r_cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
                end
                if (w_err_set) begin
                    r_err <= 1'b1;
                end
            end
            if (w_scl_store) begin
                r_scl <= i_dat;
            end
            if (w_x_store) begin
                r_x <= i_dat;
            end
        end
    end

    bn128_loader_out_stage #(
        .DAT_BITS (DAT_BITS)
    ) u_out_stage (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_load),
        .i_scl     (r_scl),
        .i_pnt     ({i_dat, r_x}),
        .i_scl_rdy (i_scl_rdy),
        .i_pnt_rdy (i_pnt_rdy),
        .o_scl_val (o_scl_val),
        .o_scl_dat (o_scl_dat),
        .o_pnt_val (o_pnt_val),
        .o_pnt_dat (o_pnt_dat),
        .o_free    (w_free)
    );

    assign o_dat_rdy = w_rdy;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;

endmodule

// File: tb/tb_bn128_multiexp_loader.sv
// Directed and randomized bench for bn128_multiexp_loader with a queue-based
// reference: intact elements are forwarded in order, stray beats are dropped.
module tb_bn128_multiexp_loader;
    import bn128_pkg::*;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_start = 1'b0;
    logic [63:0]  i_num_in = 64'd0;
    logic         i_dat_val = 1'b0;
    logic         i_dat_sop = 1'b0;
    logic         i_dat_eop = 1'b0;
    logic [255:0] i_dat = 256'd0;
    logic         o_dat_rdy;
    logic         o_scl_val;
    logic [255:0] o_scl_dat;
    logic         i_scl_rdy = 1'b1;
    logic         o_pnt_val;
    logic [511:0] o_pnt_dat;
    logic         i_pnt_rdy = 1'b1;
    logic         o_busy;
    logic         o_done;
    logic         o_err;

    bn128_multiexp_loader dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_num_in(i_num_in),
        .i_dat_val(i_dat_val), .i_dat_sop(i_dat_sop), .i_dat_eop(i_dat_eop), .i_dat(i_dat),
        .o_dat_rdy(o_dat_rdy), .o_scl_val(o_scl_val), .o_scl_dat(o_scl_dat), .i_scl_rdy(i_scl_rdy),
        .o_pnt_val(o_pnt_val), .o_pnt_dat(o_pnt_dat), .i_pnt_rdy(i_pnt_rdy),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int n_done, n_busy, n_rdy;
    int first_rise, hs_cyc, done_cyc;
    logic prev_val = 1'b0;
    bit rand_rdy = 1'b0;

    logic [255:0] q_scl[$];
    logic [511:0] q_pnt[$];
    logic [255:0] exp_scl[$];
    logic [511:0] exp_pnt[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records handshakes, done pulses and activity at the falling edge.
    always @(negedge clk) begin
        if (o_scl_val && i_scl_rdy) begin q_scl.push_back(o_scl_dat); hs_cyc = cyc; end
        if (o_pnt_val && i_pnt_rdy) begin q_pnt.push_back(o_pnt_dat); hs_cyc = cyc; end
        if (o_scl_val && !prev_val && first_rise < 0) first_rise = cyc;
        prev_val = o_scl_val;
        if (o_done) begin n_done++; done_cyc = cyc; end
        if (o_busy) n_busy++;
        if (o_dat_rdy) n_rdy++;
    end

    // Random downstream back-pressure when enabled.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            i_scl_rdy = 1'($urandom_range(0, 1));
            i_pnt_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        v[255:252] = 4'h0;
        return v;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic clear_stats();
        n_done = 0; n_busy = 0; n_rdy = 0;
        first_rise = -1; hs_cyc = -1; done_cyc = -1;
    endtask

    task automatic start(input logic [63:0] num);
        i_start = 1'b1; i_num_in = num;
        step(1);
        i_start = 1'b0;
    endtask

    // Present one beat until accepted; returns the monitor cycle of acceptance.
    task automatic send_beat(input logic sop, input logic eop, input logic [255:0] d, output int acc);
        logic ok;
        int k;
        ok = 1'b0; k = 0; acc = -1;
        i_dat_val = 1'b1; i_dat_sop = sop; i_dat_eop = eop; i_dat = d;
        while (!ok && k < 300) begin
            @(negedge clk);
            ok = o_dat_rdy; acc = cyc;
            @(posedge clk); #1;
            k++;
        end
        i_dat_val = 1'b0;
        check("beat_accept", {511'd0, ok}, 512'd1);
    endtask

    task automatic send_elem(input logic [255:0] s, input logic [255:0] x, input logic [255:0] y, output int acc_y);
        int a;
        send_beat(1'b1, 1'b0, s, a);
        send_beat(1'b0, 1'b0, x, a);
        send_beat(1'b0, 1'b1, y, acc_y);
    endtask

    task automatic expect_pair(input logic [255:0] s, input logic [255:0] x, input logic [255:0] y);
        exp_scl.push_back(s);
        exp_pnt.push_back({y, x});
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (n_done == 0 && k < limit) begin @(negedge clk); k++; end
        step(1);
        check("done_pulse_count", 512'(n_done), 512'd1);
    endtask

    task automatic compare_streams(input string tag);
        check({tag, "_scl_count"}, 512'(q_scl.size()), 512'(exp_scl.size()));
        check({tag, "_pnt_count"}, 512'(q_pnt.size()), 512'(exp_pnt.size()));
        for (int i = 0; i < exp_scl.size() && i < q_scl.size(); i++)
            check({tag, "_scl"}, {256'd0, q_scl[i]}, {256'd0, exp_scl[i]});
        for (int i = 0; i < exp_pnt.size() && i < q_pnt.size(); i++)
            check({tag, "_pnt"}, q_pnt[i], exp_pnt[i]);
        q_scl.delete(); q_pnt.delete(); exp_scl.delete(); exp_pnt.delete();
    endtask

    initial begin
        int acc_y, a, n_el;
        logic exp_err;
        logic [255:0] s, x, y;

        clear_stats();
        step(3);
        i_rst = 1'b0;
        step(1);

        // Reset state
        check("rst_scl_val", {511'd0, o_scl_val}, 512'd0);
        check("rst_pnt_val", {511'd0, o_pnt_val}, 512'd0);
        check("rst_busy", {511'd0, o_busy}, 512'd0);
        check("rst_done", {511'd0, o_done}, 512'd0);
        check("rst_err", {511'd0, o_err}, 512'd0);
        check("rst_dat_rdy", {511'd0, o_dat_rdy}, 512'd0);

        // 1: two back-to-back elements, both outputs always ready
        clear_stats();
        start(64'd2);
        send_elem(256'h5, 256'h6, 256'h7, acc_y);
        expect_pair(256'h5, 256'h6, 256'h7);
        s = rnd(); x = rnd(); y = rnd();
        send_elem(s, x, y, a);
        expect_pair(s, x, y);
        wait_done(100);
        check("t1_latency", 512'(first_rise), 512'(acc_y + 1));
        check("t1_done_after_handoff", 512'(done_cyc), 512'(hs_cyc + 1));
        check("t1_err", {511'd0, o_err}, 512'd0);
        compare_streams("t1");

        // 2: empty run
        clear_stats();
        start(64'd0);
        step(5);
        check("t2_done", 512'(n_done), 512'd1);
        check("t2_busy_cycles", 512'(n_busy), 512'd1);
        check("t2_rdy_cycles", 512'(n_rdy), 512'd0);

        // 3: point side stalled for 10 cycles
        clear_stats();
        i_scl_rdy = 1'b1; i_pnt_rdy = 1'b0;
        start(64'd1);
        s = rnd(); x = rnd(); y = rnd();
        send_elem(s, x, y, a);
        expect_pair(s, x, y);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_pnt_held_val", {511'd0, o_pnt_val}, 512'd1);
            check("t3_pnt_held_dat", o_pnt_dat, {y, x});
        end
        check("t3_scl_taken", 512'(q_scl.size()), 512'd1);
        check("t3_no_early_done", 512'(n_done), 512'd0);
        @(posedge clk); #1;
        i_pnt_rdy = 1'b1;
        wait_done(100);
        check("t3_done_after_pnt", 512'(done_cyc), 512'(hs_cyc + 1));
        compare_streams("t3");

        // 4: repeated sop restarts the element
        clear_stats();
        start(64'd1);
        s = rnd(); x = rnd(); y = rnd();
        send_beat(1'b1, 1'b0, rnd(), a);
        send_elem(s, x, y, a);
        expect_pair(s, x, y);
        wait_done(100);
        check("t4_err", {511'd0, o_err}, 512'd1);
        compare_streams("t4");

`ifdef BN128_LOADER_RANGE_CHECK_EN
        // 5: out-of-range Y is dropped, next element forwarded
        clear_stats();
        start(64'd1);
        send_elem(rnd(), rnd(), P, a);
        s = rnd(); x = rnd(); y = rnd();
        send_elem(s, x, y, a);
        expect_pair(s, x, y);
        wait_done(100);
        check("t5_err", {511'd0, o_err}, 512'd1);
        compare_streams("t5");
`endif

        // 6: reset in the middle of an element
        clear_stats();
        start(64'd2);
        send_beat(1'b0, 1'b0, rnd(), a);
        send_beat(1'b1, 1'b0, rnd(), a);
        send_beat(1'b0, 1'b0, rnd(), a);
        check("t6_err_before_rst", {511'd0, o_err}, 512'd1);
        i_rst = 1'b1;
        step(1);
        i_rst = 1'b0;
        check("t6_rst_scl_val", {511'd0, o_scl_val}, 512'd0);
        check("t6_rst_pnt_val", {511'd0, o_pnt_val}, 512'd0);
        check("t6_rst_busy", {511'd0, o_busy}, 512'd0);
        check("t6_rst_err", {511'd0, o_err}, 512'd0);
        clear_stats();
        start(64'd1);
        s = rnd(); x = rnd(); y = rnd();
        send_elem(s, x, y, a);
        expect_pair(s, x, y);
        wait_done(100);
        check("t6_err_after", {511'd0, o_err}, 512'd0);
        compare_streams("t6");

        // 7: randomized runs with back-pressure, gaps and stray beats
        rand_rdy = 1'b1;
        for (int run = 0; run < 4; run++) begin
            clear_stats();
            n_el = int'($urandom_range(3, 6));
            exp_err = 1'b0;
            start(64'(n_el));
            for (int e = 0; e < n_el; e++) begin
                if ($urandom_range(0, 3) == 0) begin
                    send_beat(1'b0, 1'($urandom_range(0, 1)), rnd(), a);
                    exp_err = 1'b1;
                end
                step(int'($urandom_range(0, 2)));
                s = rnd(); x = rnd(); y = rnd();
                send_elem(s, x, y, a);
                expect_pair(s, x, y);
            end
            wait_done(2000);
            check("t7_err", {511'd0, o_err}, {511'd0, exp_err});
            compare_streams("t7");
        end
        rand_rdy = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
